// File: rtl/frame_pkg.sv
// Shared types and default timing constants for the frame sequencer and its timer.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    STEP   = 2'd2,
    SHOW   = 2'd3
  } seq_state_t;

  // 60 Hz frame rate from a 25 MHz system clock.
  localparam int unsigned FRAME_CYCLES_DEFAULT = 416_667;
  localparam int unsigned IMU_TIMEOUT_DEFAULT  = 4096;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame period counter; tick marks the last cycle of every period.
module frame_timer
  import frame_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned    CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] tick_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: IMU sample, physics step, LED refresh, with matrix lock,
// frame counter and sticky overrun / IMU-timeout flags.
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
  parameter int unsigned IMU_TIMEOUT  = IMU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        imu_done,
  input  logic        phys_done,
  input  logic        led_done,
  output logic        imu_start,
  output logic        phys_step,
  output logic        led_start,
  output logic        matrix_lock,
  output logic [1:0]  state_dbg,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic        imu_timeout
);

  localparam int unsigned       WAIT_W    = $clog2(IMU_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMU_TIMEOUT - 1);

  seq_state_t        state, next_state;
  logic              tick;
  logic [WAIT_W-1:0] wait_cnt;
  logic              imu_expired;
  logic              imu_start_d, phys_step_d, led_start_d, matrix_lock_d;

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Expiry lands on the IMU_TIMEOUT-th SAMPLE cycle; wait_cnt is 0 in the first.
  assign imu_expired = (state == SAMPLE) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state takes its default before the case so that no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (tick && run)             next_state = SAMPLE;
      SAMPLE:  if (imu_done || imu_expired) next_state = STEP;
      STEP:    if (phys_done)               next_state = SHOW;
      SHOW:    if (led_done)                next_state = IDLE;
      default:                              next_state = IDLE;
    endcase
  end

  // Start pulses fire on state entry and are registered, so they appear in the
  // first cycle of the new state.
  always_comb begin
    imu_start_d   = (next_state == SAMPLE) && (state != SAMPLE);
    phys_step_d   = (next_state == STEP)   && (state != STEP);
    led_start_d   = (next_state == SHOW)   && (state != SHOW);
    matrix_lock_d = (next_state == SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imu_start   <= 1'b0;
      phys_step   <= 1'b0;
      led_start   <= 1'b0;
      matrix_lock <= 1'b0;
      wait_cnt    <= '0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      imu_timeout <= 1'b0;
    end else begin
      imu_start   <= imu_start_d;
      phys_step   <= phys_step_d;
      led_start   <= led_start_d;
      matrix_lock <= matrix_lock_d;
      wait_cnt    <= (state == SAMPLE) ? wait_cnt + 1'b1 : '0;
      if ((state == SHOW) && led_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      // A tick during an in-flight frame is dropped, never queued.
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      if (imu_expired && !imu_done) begin
        imu_timeout <= 1'b1;
      end
    end
  end

  assign state_dbg = state;

endmodule
